// File: rtl/rram_func_core.sv
// Behavioural functional core for a 32x32 ReRAM array: command decode, timed SET/RESET/READ pulses and a row-result FIFO.
// Optional macro RRAM_STATUS_EN: an empty-FIFO read returns a status word instead of zero.
module rram_func_core #(
  parameter int PULSE_CYCLES = 8,
  parameter int READ_CYCLES  = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        EN,
  input  logic        R_WB,
  input  logic [31:0] DI,
  input  logic [31:0] AD,
  input  logic [3:0]  SEL,
  output logic [31:0] DO,
  output logic        func_ack
);

  localparam int CNT_MAX = (PULSE_CYCLES > READ_CYCLES) ? PULSE_CYCLES : READ_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW    = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]   PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]   SENSE_LAST = CW'(READ_CYCLES - 1);
  localparam logic [PW-1:0]   PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [CNTW-1:0] FIFO_FULL  = CNTW'(FIFO_DEPTH);

  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  typedef enum logic [1:0] {IDLE, PULSE, SENSE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1:0]      op_reg;
  logic [4:0]      row_reg, col_reg;

  logic [31:0]     mem [0:31];
  logic [31:0]     sense_row_reg;
  logic [4:0]      rd_addr;

  logic [31:0]     fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] fifo_count_reg;
  logic            ovf_reg;

  logic            rd_acc, wr_acc, mem_we, push, pop, full, push_ok, ovf_set, status_clr;
  logic [31:0]     empty_word;

  // AD and SEL are decoded upstream; DI low bits carry no command fields.
  logic unused_bits;

  assign rd_acc  = EN & R_WB & ~func_ack;
  assign full    = (fifo_count_reg == FIFO_FULL);
  assign pop     = rd_acc & (fifo_count_reg != '0);
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

`ifdef RRAM_STATUS_EN
  assign empty_word  = {(state_reg != IDLE), ovf_reg, 26'd0, 4'(fifo_count_reg)};
  assign status_clr  = rd_acc & ~pop;
  assign unused_bits = ^{AD, SEL, DI[19:0]};
`else
  assign empty_word  = 32'h0;
  assign status_clr  = 1'b0;
  assign unused_bits = ^{AD, SEL, DI[19:0], ovf_reg};
`endif

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_acc     = 1'b0;
    mem_we     = 1'b0;
    push       = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (EN && !R_WB && !func_ack) begin
          wr_acc = 1'b1;
          if (DI[31:30] == OP_SET || DI[31:30] == OP_RESET) state_next = PULSE;
          else if (DI[31:30] == OP_READ)                   state_next = SENSE;
        end
      end
      PULSE: begin
        if (cnt_reg == PULSE_LAST) begin
          mem_we     = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SENSE: begin
        if (cnt_reg == SENSE_LAST) begin
          push       = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLKin) begin
    if (wr_acc) begin
      op_reg  <= DI[31:30];
      row_reg <= DI[29:25];
      col_reg <= DI[24:20];
    end
  end

  // Array is non-volatile: no reset, and a reset cycle never commits a write.
  assign rd_addr = (state_reg == IDLE) ? DI[29:25] : row_reg;

  always_ff @(posedge CLKin) begin
    if (mem_we && !RSTin) mem[row_reg][col_reg] <= (op_reg == OP_SET);
    sense_row_reg <= mem[rd_addr];
  end

  always_ff @(posedge CLKin) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= sense_row_reg;
  end

  always_ff @(posedge CLKin) begin
    if (RSTin) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      ovf_reg        <= 1'b0;
      DO             <= 32'h0;
      func_ack       <= 1'b0;
    end else begin
      func_ack <= rd_acc | wr_acc;
      if (push_ok) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
      if (ovf_set)         ovf_reg <= 1'b1;
      else if (status_clr) ovf_reg <= 1'b0;
      if (rd_acc) DO <= pop ? fifo_mem[rd_ptr_reg] : empty_word;
    end
  end

endmodule

// File: tb/tb_rram_func_core.sv
// Self-checking bench for rram_func_core: bus-level stimulus against a transaction-level array/FIFO model.
// Build with RRAM_STATUS_EN defined to exercise the status-word path.
module tb_rram_func_core;

  localparam int P = 8;
  localparam int R = 4;
  localparam int D = 4;
  localparam int WAIT_IDLE = ((P > R) ? P : R) + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        r_wb;
  logic [31:0] di;
  logic [31:0] ad;
  logic [3:0]  sel;
  logic [31:0] do_w;
  logic        ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_q [$];
  bit          m_ovf;
  logic [31:0] last_do;

  rram_func_core #(.PULSE_CYCLES(P), .READ_CYCLES(R), .FIFO_DEPTH(D)) dut (
    .CLKin(clk), .RSTin(rst), .EN(en), .R_WB(r_wb), .DI(di), .AD(ad), .SEL(sel),
    .DO(do_w), .func_ack(ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_cmd(input logic [1:0] op, input int row, input int col);
    return {op, 5'(row), 5'(col), 20'($urandom)};
  endfunction

  // Reference model: command effects applied as whole transactions.
  function automatic void m_cmd(input logic [31:0] c);
    case (c[31:30])
      2'b01: m_mem[c[29:25]][c[24:20]] = 1'b1;
      2'b10: m_mem[c[29:25]][c[24:20]] = 1'b0;
      2'b11: if (m_q.size() < D) m_q.push_back(m_mem[c[29:25]]); else m_ovf = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] w;
    if (m_q.size() > 0) return m_q.pop_front();
`ifdef RRAM_STATUS_EN
    w = {1'b0, m_ovf, 26'd0, 4'(m_q.size())};
    m_ovf = 1'b0;
`else
    w = 32'h0;
`endif
    return w;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    last_do = 32'h0;
  endfunction

  task automatic bus_xfer(input logic rw, input logic [31:0] cmd, output int lat);
    lat = 0;
    @(negedge clk);
    en = 1'b1; r_wb = rw; di = cmd; ad = $urandom; sel = 4'($urandom);
    do begin
      @(posedge clk); @(negedge clk); lat++;
    end while (!ack && lat < 200);
    en = 1'b0;
    if (!ack) begin
      n_cmp++; n_err++;
      $display("FAIL bus_timeout rw=%0b cmd=%h: no ack after %0d cycles, required ack", rw, cmd, lat);
    end
    $display("xfer rw=%0b di=%h lat=%0d DO=%h", rw, cmd, lat, do_w);
  endtask

  task automatic wait_idle();
    repeat (WAIT_IDLE) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    int lat;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (do_w !== 32'h0 || ack !== 1'b0) begin
      n_err++; $display("FAIL reset_state: DO=%h ack=%b, required DO=0 ack=0", do_w, ack);
    end
    rst = 1'b0;
    m_reset();
    bus_xfer(1'b1, 32'h0, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL reset_read_lat: %0d, required 1", lat); end
    n_cmp++;
    if (do_w !== 32'h0 || do_w !== m_read()) begin
      n_err++; $display("FAIL reset_read_do: %h, required 00000000", do_w);
    end
  endtask

  task automatic test_set_read();
    int lat;
    bus_xfer(1'b0, 32'h46500000, lat); m_cmd(32'h46500000); wait_idle();
    bus_xfer(1'b0, 32'hC6000000, lat); m_cmd(32'hC6000000); wait_idle();
    bus_xfer(1'b1, 32'h0, lat);
    n_cmp++;
    if (do_w !== 32'h00000020) begin n_err++; $display("FAIL set_read_row3: %h, required 00000020", do_w); end
    void'(m_read());
    last_do = do_w;
  endtask

  task automatic test_back_to_back();
    int gap;
    int lat;
    logic [31:0] c;
    c = mk_cmd(2'b01, 4, 9);
    bus_xfer(1'b0, c, lat); m_cmd(c);
    en = 1'b1; r_wb = 1'b0; di = mk_cmd(2'b00, 0, 0);
    gap = 0;
    do begin
      @(posedge clk); @(negedge clk); gap++;
    end while (!ack && gap < 200);
    en = 1'b0;
    $display("xfer rw=0 di=%h gap=%0d", di, gap);
    n_cmp++;
    if (gap !== P + 1) begin n_err++; $display("FAIL stall_gap: %0d cycles, required %0d", gap, P + 1); end
    n_cmp++;
    if (do_w !== last_do) begin n_err++; $display("FAIL wr_ack_do_hold: %h, required %h", do_w, last_do); end
    c = mk_cmd(2'b11, 4, 0);
    bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    bus_xfer(1'b1, 32'h0, lat);
    n_cmp++;
    if (do_w !== m_read() || do_w[9] !== 1'b1) begin
      n_err++; $display("FAIL b2b_row4: %h, required bit9 set", do_w);
    end
    last_do = do_w;
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] exp;
    logic [31:0] c;
    for (int i = 0; i < 5; i++) begin
      c = mk_cmd(2'b11, 0, 0);
      bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    end
    for (int i = 0; i < 6; i++) begin
      bus_xfer(1'b1, 32'h0, lat);
      exp = m_read();
      n_cmp++;
      if (do_w !== exp) begin n_err++; $display("FAIL ovf_read%0d: %h, required %h", i, do_w, exp); end
      last_do = do_w;
    end
`ifdef RRAM_STATUS_EN
    n_cmp++;
    if (exp !== 32'h0) begin n_err++; $display("FAIL ovf_cleared_model: %h, required 0", exp); end
`endif
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] c;
    c = mk_cmd(2'b01, 2, 7);
    bus_xfer(1'b0, c, lat);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_reset();
    n_cmp++;
    if (do_w !== 32'h0) begin n_err++; $display("FAIL mid_reset_do: %h, required 0", do_w); end
    c = mk_cmd(2'b11, 2, 0);
    bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    bus_xfer(1'b1, 32'h0, lat);
    n_cmp++;
    if (do_w !== m_read() || do_w[7] !== 1'b0) begin
      n_err++; $display("FAIL abandoned_set: row2=%h, required bit7 clear", do_w);
    end
    c = mk_cmd(2'b01, 1, 0);
    bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    pulse_reset();
    c = mk_cmd(2'b11, 1, 0);
    bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    bus_xfer(1'b1, 32'h0, lat);
    n_cmp++;
    if (do_w !== 32'h1 || do_w !== m_read()) begin
      n_err++; $display("FAIL nonvolatile_row1: %h, required 00000001", do_w);
    end
    last_do = do_w;
  endtask

  task automatic test_held_read();
    int lat;
    logic [31:0] c;
    logic        exp_ack;
    logic [31:0] exp;
    c = mk_cmd(2'b11, 3, 0); bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    c = mk_cmd(2'b11, 4, 0); bus_xfer(1'b0, c, lat); m_cmd(c); wait_idle();
    @(negedge clk);
    en = 1'b1; r_wb = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      exp_ack = (k == 1 || k == 3);
      $display("xfer held-read cycle=%0d ack=%b DO=%h", k + 1, ack, do_w);
      n_cmp++;
      if (ack !== exp_ack) begin n_err++; $display("FAIL held_ack_c%0d: %b, required %b", k + 1, ack, exp_ack); end
      if (exp_ack) begin
        exp = m_read();
        n_cmp++;
        if (do_w !== exp) begin n_err++; $display("FAIL held_do_c%0d: %h, required %h", k + 1, do_w, exp); end
        last_do = do_w;
      end
    end
    en = 1'b0;
    bus_xfer(1'b1, 32'h0, lat);
    exp = m_read();
    n_cmp++;
    if (do_w !== exp) begin n_err++; $display("FAIL held_after_empty: %h, required %h", do_w, exp); end
    last_do = do_w;
  endtask

  task automatic test_random();
    int lat;
    int kind;
    logic [31:0] c;
    logic [31:0] exp;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      if (kind < 4) begin
        c = mk_cmd(2'(kind), $urandom_range(0, 3), $urandom_range(0, 31));
        bus_xfer(1'b0, c, lat);
        m_cmd(c);
        n_cmp++;
        if (lat !== 1 || do_w !== last_do) begin
          n_err++; $display("FAIL rnd_wr%0d: lat=%0d DO=%h, required lat=1 DO=%h", i, lat, do_w, last_do);
        end
        wait_idle();
      end else begin
        bus_xfer(1'b1, 32'h0, lat);
        exp = m_read();
        n_cmp++;
        if (lat !== 1 || do_w !== exp) begin
          n_err++; $display("FAIL rnd_rd%0d: lat=%0d DO=%h, required lat=1 DO=%h", i, lat, do_w, exp);
        end
        last_do = do_w;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_reset();
    rst = 1'b0; en = 1'b0; r_wb = 1'b0; di = '0; ad = '0; sel = '0;
    test_reset();
    test_set_read();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_held_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rram_func_core.md
# rram_func_core

Behavioural functional core for the 32x32 neuromorphic ReRAM array. It sits directly downstream of the Wishbone slave interface and consumes its core-side bus: `EN`, `R_WB`, `DI`, `AD`, `SEL`, `CLKin` and `RSTin`. It returns `DO` and `func_ack`. Command words written over the bus program, erase or read the array using multi-cycle pulse timing. Row-read results are buffered in a small FIFO, and Wishbone reads drain that FIFO.

## Interface
Parameters:
- `PULSE_CYCLES`, default 8: duration of a SET or RESET pulse, in clocks (≥1).
- `READ_CYCLES`, default 4: duration of a row-sense operation, in clocks (≥1).
- `FIFO_DEPTH`, default 4: depth of the result FIFO. Power of two, ≤8.

Ports:
- `CLKin` in 1: core clock. This is the single clock domain.
- `RSTin` in 1: reset, synchronous, active-high.
- `EN` in 1: transaction valid. Held high by the bus until `func_ack`.
- `R_WB` in 1: 1 = read (drain FIFO), 0 = write (command).
- `DI` in 32: command word.
- `AD` in 32: address. Already decoded upstream; ignored here.
- `SEL` in 4: byte select. Already qualified upstream; ignored here.
- `DO` out 32: read data.
- `func_ack` out 1: single-cycle transaction acknowledge.

## Operation
Command word (`DI`, write only):
- `[31:30]` opcode: 00 NOP, 01 SET bit, 10 RESET bit, 11 READ row.
- `[29:25]` row.
- `[24:20]` column, used by SET/RESET only.
- All other bits are ignored.

Array:
- Storage is `mem[0:31][31:0]`.
- The array is non-volatile and is NOT cleared by reset. At simulation start it holds all-zero.

FSM states:
- `IDLE`
  - Write accept (`EN & ~R_WB & ~func_ack`):
    - Latch the opcode, row and column.
    - Go to `PULSE` for SET/RESET, `SENSE` for READ, or stay in `IDLE` for NOP.
- `PULSE`
  - Counter runs 0..`PULSE_CYCLES`-1.
  - On the last count: write `mem[row][col]` to 1 (SET) or 0 (RESET), then return to `IDLE`.
- `SENSE`
  - Counter runs 0..`READ_CYCLES`-1.
  - On the last count: push `mem[row]` into the FIFO, then return to `IDLE`.
  - If the FIFO is full, drop the push and set sticky `ovf`.

Write handshake:
- A write is accepted only in `IDLE`.
- While the core is busy (`PULSE`/`SENSE`), a write `EN` is stalled with no ack until the FSM returns to `IDLE`.

Read handshake:
- A read is accepted in any state (`EN & R_WB & ~func_ack`). Reads never stall.
- FIFO non-empty: `DO` is loaded with the FIFO head and the entry is popped.
- FIFO empty: `DO` is loaded with the empty-read word (see Configuration).

Simultaneous events:
- A SENSE push and a read pop in the same cycle are both performed; the FIFO count is unchanged.
  - A push into a full FIFO in a cycle that also pops is accepted (not an overflow).
- A read accepted on the cycle `SENSE` completes into an empty FIFO returns the empty-read word. The pushed entry is returned on the next read.

Hold behaviour:
- `DO` holds its value until the next read ack.
- Write acks do not change `DO`.

Reset values:
- `DO` = 0, `func_ack` = 0.
- FSM = `IDLE`, counter = 0.
- FIFO empty, `ovf` = 0.

Reset mid-operation:
- A pending SET/RESET is abandoned and the array bit is unchanged.
- A pending READ is abandoned with no push.

## Timing
- Write accepted in cycle N: `func_ack` high in N+1.
  - First `PULSE`/`SENSE` cycle is N+1.
  - The array update or FIFO push occurs at the end of cycle N+`PULSE_CYCLES` (or N+`READ_CYCLES`).
  - The FSM is in `IDLE` at cycle N+`PULSE_CYCLES`+1.
- Read accepted in cycle N: `func_ack` and the new `DO` are valid in N+1.
- `func_ack` is registered and exactly one cycle wide.
- `EN` sampled high in the ack cycle is ignored, so a held strobe never double-accepts.
- Back-to-back: the earliest next accept is N+2.

## Configuration
Macro `RRAM_STATUS_EN`:
- Defined: an empty-FIFO read returns a status word.
  - bit31 = busy (FSM ≠ `IDLE`).
  - bit30 = `ovf`.
  - bits[3:0] = FIFO count.
  - All other bits are 0.
  - The status read clears `ovf` (the returned word shows the pre-clear value).
- Not defined: an empty-FIFO read returns 32'h0.
  - `ovf` is still tracked but is never observable.

## Test plan
- Reset, then read. Required: ack in cycle 2. `DO` = 32'h0 in both builds (status word is 0: idle, no overflow, empty FIFO).
- Write SET row 3 col 5 (`DI` = 32'h46500000), wait for idle, write READ row 3 (`DI` = 32'hC6000000), wait, then read. Required: `DO` = 32'h00000020.
- SET issued, then an immediate second write held on `EN`. Required: the second ack arrives exactly `PULSE_CYCLES`+1 cycles after the first.
- 5 READ commands of row 0 with no drains (`FIFO_DEPTH` = 4), then read ×5 with `RRAM_STATUS_EN`:
  - Required: four reads return 0.
  - The 5th returns 32'h40000000.
  - A 6th returns 32'h0 (`ovf` cleared).
- Assert `RSTin` at the 3rd cycle of a SET pulse, then READ that row. Required: the bit is still 0. Then SET row 1 col 0 completed, `RSTin` pulsed, READ row 1. Required: `DO` = 32'h1 (array survives reset).
- Hold `EN` high with `R_WB` = 1 for 4 cycles with the FIFO holding 2 entries. Required: 2 acks (cycles 2 and 4), both entries popped in order.
